// File: rtl/arp_tx_queued.sv
// ARP request/reply transmitter: request FIFO, GMII byte stream, external CRC32 hookup.
// Optional gratuitous-ARP timer is compiled in when ARP_TX_GARP_EN is defined.
module arp_tx_queued #(
  parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP    = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [47:0] DES_MAC     = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] DES_IP      = {8'd192, 8'd168, 8'd1, 8'd102},
  parameter int          QUEUE_AW    = 2,
  parameter int          IFG_CYCLES  = 12,
  parameter int          GARP_PERIOD = 125_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_type,
  input  logic [47:0] req_mac,
  input  logic [31:0] req_ip,
  input  logic [31:0] crc_data,
  input  logic [7:0]  crc_next,
  output logic        gmii_txd_valid,
  output logic [7:0]  gmii_txd_data,
  output logic        crc_en,
  output logic        crc_clr,
  output logic        tx_done,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  // Handshake: a request is taken on every rising edge where req_valid && req_ready;
  // req_ready depends only on queue occupancy, never on req_valid.

  localparam int                DEPTH    = 2 ** QUEUE_AW;
  localparam int                ENTRY_W  = 1 + 48 + 32;
  localparam logic [QUEUE_AW:0] Q_FULL   = (QUEUE_AW + 1)'(DEPTH);
  localparam logic [7:0]        IFG_LAST = 8'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    ARP_DATA = 3'd3,
    CRC      = 3'd4,
    IFG      = 3'd5
  } state_t;

  state_t             state;
  logic [6:0]         idx;
  logic [6:0]         nidx;
  logic [7:0]         gap_cnt;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [QUEUE_AW-1:0] wr_ptr;
  logic [QUEUE_AW-1:0] rd_ptr;
  logic [QUEUE_AW:0]  q_count;
  logic               q_nonempty;
  logic               push;
  logic               pop;
  logic               start;
  logic               garp_pend;
  logic               garp_take;

  logic [ENTRY_W-1:0] head;
  logic               h_type;
  logic [47:0]        h_mac;
  logic [31:0]        h_ip;
  logic               h_dflt;

  logic               cur_op;
  logic [47:0]        cur_dmac;
  logic [47:0]        cur_tmac;
  logic [31:0]        cur_tip;
  logic [479:0]       hdr;
  logic [479:0]       hdr_shift;
  logic [6:0]         hdr_sel;
  logic [7:0]         next_byte;
  logic               unused_sig;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign q_nonempty = (q_count != '0);
  assign req_ready  = (q_count != Q_FULL);
  assign push       = req_valid && req_ready;
  assign start      = (state == IDLE) && (garp_pend || q_nonempty);
  assign garp_take  = (state == IDLE) && garp_pend;
  assign pop        = (state == IDLE) && !garp_pend && q_nonempty;

  assign head                   = mem[rd_ptr];
  assign {h_type, h_mac, h_ip}  = head;
  assign h_dflt                 = (h_mac == '0) && (h_ip == '0);

  assign busy       = (state != IDLE);
  assign fsm_state  = state;
  assign unused_sig = ^{crc_data[31:24], garp_take};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_type, req_mac, req_ip};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

`ifdef ARP_TX_GARP_EN
  localparam int            GW     = (GARP_PERIOD > 2) ? $clog2(GARP_PERIOD) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GARP_PERIOD - 1);

  logic [GW-1:0] garp_timer;
  logic          garp_hit;

  assign garp_hit = (garp_timer == G_LAST);

  // An expiry while a gratuitous frame is still pending folds into that one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      garp_timer <= '0;
      garp_pend  <= 1'b0;
    end else begin
      garp_timer <= garp_hit ? '0 : garp_timer + 1'b1;
      garp_pend  <= (garp_pend && !garp_take) || garp_hit;
    end
  end
`else
  assign garp_pend = 1'b0;
`endif

  // 60 header+payload bytes, first byte in the top lane.
  assign hdr = {cur_dmac, BOARD_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00,
                cur_op ? 8'h02 : 8'h01, BOARD_MAC, BOARD_IP, cur_tmac, cur_tip, 144'h0};

  assign nidx      = idx + 7'd1;
  assign hdr_sel   = nidx - 7'd8;
  assign hdr_shift = hdr << (8 * hdr_sel);

  always_comb begin
    next_byte = 8'h55;
    if (nidx == 7'd7)      next_byte = 8'hd5;
    else if (nidx >= 7'd8) next_byte = hdr_shift[479:472];
  end

  // Outputs are registered: each edge loads the byte that goes on the wire next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      idx            <= '0;
      gap_cnt        <= '0;
      gmii_txd_valid <= 1'b0;
      gmii_txd_data  <= '0;
      crc_en         <= 1'b0;
      crc_clr        <= 1'b0;
      tx_done        <= 1'b0;
      cur_op         <= 1'b0;
      cur_dmac       <= '0;
      cur_tmac       <= '0;
      cur_tip        <= '0;
    end else begin
      tx_done <= 1'b0;
      crc_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= PREAMBLE;
            idx            <= '0;
            gmii_txd_valid <= 1'b1;
            gmii_txd_data  <= 8'h55;
            if (garp_pend) begin
              cur_op   <= 1'b0;
              cur_dmac <= 48'hff_ff_ff_ff_ff_ff;
              cur_tmac <= '0;
              cur_tip  <= BOARD_IP;
            end else if (h_dflt) begin
              cur_op   <= h_type;
              cur_dmac <= DES_MAC;
              cur_tmac <= DES_MAC;
              cur_tip  <= DES_IP;
            end else begin
              cur_op   <= h_type;
              cur_dmac <= h_mac;
              cur_tmac <= h_mac;
              cur_tip  <= h_ip;
            end
          end
        end
        PREAMBLE, ETH_HEAD, ARP_DATA: begin
          idx <= nidx;
          if (nidx == 7'd68) begin
            // crc_next already folds in the last payload byte on the wire.
            state         <= CRC;
            crc_en        <= 1'b0;
            gmii_txd_data <= rev8(~crc_next);
          end else begin
            gmii_txd_data <= next_byte;
            crc_en        <= (nidx >= 7'd8);
            if (nidx == 7'd8)       state <= ETH_HEAD;
            else if (nidx == 7'd22) state <= ARP_DATA;
          end
        end
        CRC: begin
          if (idx == 7'd71) begin
            gmii_txd_valid <= 1'b0;
            gmii_txd_data  <= '0;
            tx_done        <= 1'b1;
            crc_clr        <= 1'b1;
            gap_cnt        <= '0;
            state          <= (IFG_CYCLES > 1) ? IFG : IDLE;
          end else begin
            idx <= nidx;
            case (nidx)
              7'd69:   gmii_txd_data <= rev8(~crc_data[23:16]);
              7'd70:   gmii_txd_data <= rev8(~crc_data[15:8]);
              default: gmii_txd_data <= rev8(~crc_data[7:0]);
            endcase
          end
        end
        IFG: begin
          // The IDLE cycle that launches the next frame is the last gap cycle.
          if (gap_cnt == IFG_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_tx_queued.sv
// Bench for arp_tx_queued: frame scoreboard with a reference CRC32, timing and reset scenarios.
// Define ARP_TX_GARP_EN to run the gratuitous-ARP scenario instead of the queue scenarios.
module tb_arp_tx_queued;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hc0a8_010a;
  localparam logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [31:0] DES_IP    = 32'hc0a8_0166;
  localparam int          IFG       = 12;
`ifdef ARP_TX_GARP_EN
  localparam int          GP        = 200;
`else
  localparam int          GP        = 125_000_000;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_type = 1'b0;
  logic [47:0] req_mac = '0;
  logic [31:0] req_ip = '0;
  logic [31:0] crc_data;
  logic [7:0]  crc_next;
  logic        gmii_txd_valid;
  logic [7:0]  gmii_txd_data;
  logic        crc_en;
  logic        crc_clr;
  logic        tx_done;
  logic        busy;
  logic [2:0]  fsm_state;

  arp_tx_queued #(
    .BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .DES_MAC(DES_MAC), .DES_IP(DES_IP),
    .QUEUE_AW(2), .IFG_CYCLES(IFG), .GARP_PERIOD(GP)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_mac(req_mac), .req_ip(req_ip),
    .crc_data(crc_data), .crc_next(crc_next),
    .gmii_txd_valid(gmii_txd_valid), .gmii_txd_data(gmii_txd_data),
    .crc_en(crc_en), .crc_clr(crc_clr), .tx_done(tx_done), .busy(busy),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- external CRC32 block stand-in (MSB-first register, LSB-first data)
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ c[31];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  logic [31:0] crc_reg;
  logic [31:0] crc_full;
  assign crc_full = crc_step(crc_reg, gmii_txd_data);
  assign crc_next = crc_full[31:24];
  assign crc_data = crc_reg;

  always @(posedge clk or negedge resetn) begin
    if (!resetn)      crc_reg <= 32'hffff_ffff;
    else if (crc_clr) crc_reg <= 32'hffff_ffff;
    else if (crc_en)  crc_reg <= crc_full;
  end

  // ---------------- reference frame model (reflected CRC32, FCS sent LSB byte first)
  function automatic logic [575:0] build_frame(input logic op_type, input logic [47:0] dmac,
                                               input logic [47:0] tmac, input logic [31:0] tip);
    logic [479:0] h;
    logic [7:0]   b [72];
    logic [31:0]  c;
    logic [575:0] f;
    h = {dmac, BOARD_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00,
         op_type ? 8'h02 : 8'h01, BOARD_MAC, BOARD_IP, tmac, tip, 144'h0};
    for (int i = 0; i < 7; i++) b[i] = 8'h55;
    b[7] = 8'hd5;
    for (int k = 0; k < 60; k++) b[8+k] = h[479-8*k -: 8];
    c = 32'hffff_ffff;
    for (int k = 0; k < 60; k++) begin
      c = c ^ {24'h0, b[8+k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    b[68] = c[7:0];
    b[69] = c[15:8];
    b[70] = c[23:16];
    b[71] = c[31:24];
    f = '0;
    for (int i = 0; i < 72; i++) f = {f[567:0], b[i]};
    return f;
  endfunction

  function automatic logic [575:0] expected_for(input logic t, input logic [47:0] m,
                                                input logic [31:0] ip);
    if (m == '0 && ip == '0) return build_frame(t, DES_MAC, DES_MAC, DES_IP);
    return build_frame(t, m, m, ip);
  endfunction

  // ---------------- scoreboard / monitor
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           accept_cyc = 0;
  int           stray_cnt = 0;
  logic [575:0] exp_q [$];
  int           frame_starts [$];
  logic [7:0]   fbuf [72];
  int           mon_n = 0;
  bit           in_frame = 0;
  bit           crc_bad = 0;
  logic [575:0] mon_got;
  logic [575:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetn) begin
      in_frame = 0;
      mon_n    = 0;
    end else if (gmii_txd_valid) begin
      if (!in_frame) begin
        in_frame = 1;
        mon_n    = 0;
        crc_bad  = 0;
        frame_starts.push_back(cyc);
      end
      if (mon_n < 72) fbuf[mon_n] = gmii_txd_data;
      if (crc_en !== ((mon_n >= 8) && (mon_n < 68))) crc_bad = 1;
      if (tx_done || crc_clr) stray_cnt++;
      mon_n++;
    end else if (in_frame) begin
      in_frame = 0;
      mon_got  = '0;
      for (int i = 0; i < 72; i++) mon_got = {mon_got[567:0], fbuf[i]};
      checks++;
      if (mon_n !== 72) begin
        errors++;
        $display("FAIL frame_len: got %0d expected 72", mon_n);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL frame_bytes: got %h expected %h", mon_got, mon_exp);
        end
      end
      checks++;
      if (crc_bad) begin
        errors++;
        $display("FAIL crc_en_window: got misaligned expected bytes 8..67 only");
      end
      checks++;
      if ({tx_done, crc_clr, crc_en} !== 3'b110) begin
        errors++;
        $display("FAIL done_pulse: got tx_done/crc_clr/crc_en=%b expected 110",
                 {tx_done, crc_clr, crc_en});
      end
    end else if (tx_done || crc_clr || crc_en) begin
      stray_cnt++;
    end
  end

  // ---------------- driver tasks
  task automatic push_req(input logic t, input logic [47:0] m, input logic [31:0] ip,
                          input bit expect_frame);
    int w;
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = t;
    req_mac   = m;
    req_ip    = ip;
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got req_ready=0 expected 1 within 300 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid  = 1'b0;
    if (expect_frame) exp_q.push_back(expected_for(t, m, ip));
  endtask

  task automatic wait_frames(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !in_frame && !gmii_txd_valid && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_frames: got %0d frames outstanding expected 0", exp_q.size());
    end
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom_range(1, 16'hffff)), 32'($urandom)};
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    resetn = 1'b1;
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({gmii_txd_valid, gmii_txd_data, crc_en, crc_clr, tx_done, busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {gmii_txd_valid, gmii_txd_data, crc_en, crc_clr, tx_done, busy});
    end
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", fsm_state);
    end
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    int st_exp;
    push_req(1'b0, 48'h0, 32'h0, 1);
    st_exp = accept_cyc + 1;
    wait_frames(200);
    checks++;
    if (frame_starts.size() == 0 || frame_starts[$] !== st_exp) begin
      errors++;
      $display("FAIL start_latency: got %0d expected %0d",
               (frame_starts.size() == 0) ? -1 : frame_starts[$], st_exp);
    end
  endtask

  task automatic test_reply();
    push_req(1'b1, 48'h02_aa_bb_cc_dd_ee, 32'hc0a8_0105, 1);
    wait_frames(200);
  endtask

  task automatic test_dest_edges();
    push_req(1'b0, 48'h0, 32'hc0a8_0107, 1);
    wait_frames(200);
    push_req(1'b1, 48'h02_00_00_00_00_01, 32'h0, 1);
    wait_frames(200);
  endtask

  task automatic test_back_to_back();
    int base;
    int gap;
    base = frame_starts.size();
    push_req(1'($urandom_range(0, 1)), rand_mac(), $urandom, 1);
    for (int i = 0; i < 4; i++) push_req(1'($urandom_range(0, 1)), rand_mac(), $urandom, 1);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL queue_full_ready: got %b expected 0", req_ready);
    end
    push_req(1'b1, rand_mac(), $urandom, 1);
    wait_frames(1000);
    checks++;
    if (frame_starts.size() !== base + 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 6", frame_starts.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        gap = frame_starts[base+i+1] - frame_starts[base+i] - 72;
        checks++;
        if (gap !== IFG) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d expected %0d", i, gap, IFG);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int w;
    int stray0;
    push_req(1'b0, rand_mac(), $urandom, 0);
    push_req(1'b1, rand_mac(), $urandom, 0);
    w = 0;
    while (mon_n < 30 && w < 200) begin
      @(negedge clk);
      #2;
      w++;
    end
    checks++;
    if (mon_n < 30) begin
      errors++;
      $display("FAIL reset_mid_wait: got %0d bytes expected 30", mon_n);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({gmii_txd_valid, gmii_txd_data, crc_en, crc_clr, tx_done, busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 0",
               {gmii_txd_valid, gmii_txd_data, crc_en, crc_clr, tx_done, busy});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b expected 1", req_ready);
    end
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    n0     = frame_starts.size();
    stray0 = stray_cnt;
    repeat (150) @(negedge clk);
    #2;
    checks++;
    if (frame_starts.size() !== n0 || stray_cnt !== stray0) begin
      errors++;
      $display("FAIL reset_mid_discard: got %0d frames %0d strays expected 0 0",
               frame_starts.size() - n0, stray_cnt - stray0);
    end
  endtask

  task automatic test_after_reset();
    push_req(1'b1, rand_mac(), $urandom, 1);
    wait_frames(200);
  endtask

`ifdef ARP_TX_GARP_EN
  task automatic test_garp();
    int base;
    logic [47:0] m;
    logic [31:0] ip;
    int gap;
    m    = rand_mac();
    ip   = $urandom;
    base = frame_starts.size();
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (GP - 1) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_type  = 1'b1;
    req_mac   = m;
    req_ip    = ip;
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_q.push_back(build_frame(1'b0, 48'hff_ff_ff_ff_ff_ff, 48'h0, BOARD_IP));
    exp_q.push_back(expected_for(1'b1, m, ip));
    wait_frames(400);
    checks++;
    if (frame_starts.size() !== base + 2) begin
      errors++;
      $display("FAIL garp_count: got %0d expected 2", frame_starts.size() - base);
    end else begin
      gap = frame_starts[base+1] - frame_starts[base] - 72;
      checks++;
      if (gap !== IFG) begin
        errors++;
        $display("FAIL garp_gap: got %0d expected %0d", gap, IFG);
      end
    end
  endtask
`endif

  task automatic test_no_stray();
    checks++;
    if (stray_cnt !== 0) begin
      errors++;
      $display("FAIL stray_strobes: got %0d expected 0", stray_cnt);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
`ifdef ARP_TX_GARP_EN
    test_garp();
`else
    test_single();
    test_reply();
    test_dest_edges();
    test_back_to_back();
    test_reset_mid();
    test_after_reset();
`endif
    test_no_stray();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1);
  end

endmodule
